// File: rtl/pong_pkg.sv
// Shared Pong geometry, ball FSM states and direction type.
// Coordinates are unsigned 16-bit pixel positions with the origin at the top-left corner.
package pong_pkg;

    typedef logic [15:0] coord_t;

    localparam coord_t SCREEN_WIDTH  = 16'd640;
    localparam coord_t SCREEN_HEIGHT = 16'd480;
    localparam coord_t BALL_SIZE     = 16'd8;
    localparam coord_t PADDLE_WIDTH  = 16'd20;
    localparam coord_t PADDLE2_X     = 16'd620;
    localparam coord_t PADDLE_HEIGHT = 16'd80;
    localparam coord_t SPEED_X       = 16'd2;
    localparam coord_t SPEED_Y       = 16'd2;
    localparam int unsigned SERVE_DELAY = 60;

    localparam coord_t CENTER_X = (SCREEN_WIDTH - BALL_SIZE) / 2;
    localparam coord_t CENTER_Y = (SCREEN_HEIGHT - BALL_SIZE) / 2;

    typedef enum logic [1:0] {IDLE, PLAY, MISS} ball_state_t;

    typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

    // Vertical overlap of the ball with a paddle whose top edge is paddle_y.
    function automatic logic paddle_hit(coord_t ball_y, coord_t paddle_y);
        return (ball_y + BALL_SIZE > paddle_y) && (ball_y < paddle_y + PADDLE_HEIGHT);
    endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// Frame/serve/paddle inputs and ball position/event outputs of the ball motion engine.
interface ball_motion_engine_if;
    import pong_pkg::*;

    logic   frame_tick;
    logic   serve;
    coord_t Paddle1_Y;
    coord_t Paddle2_Y;
    coord_t Ball_X;
    coord_t Ball_Y;
    logic   paddle1_collision;
    logic   paddle2_collision;
    logic   miss_left;
    logic   miss_right;
    logic   in_play;

    modport master (
        output frame_tick, serve, Paddle1_Y, Paddle2_Y,
        input  Ball_X, Ball_Y, paddle1_collision, paddle2_collision, miss_left, miss_right,
        input  in_play
    );

    modport slave (
        input  frame_tick, serve, Paddle1_Y, Paddle2_Y,
        output Ball_X, Ball_Y, paddle1_collision, paddle2_collision, miss_left, miss_right,
        output in_play
    );

endinterface

// File: rtl/serve_timer.sv
// Counts frame ticks after a miss; done fires on the tick that completes DELAY ticks.
module serve_timer
    import pong_pkg::*;
#(
    parameter int unsigned DELAY = SERVE_DELAY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int unsigned CW = $clog2(DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    logic [CW-1:0] count_q, count_d;

    assign done = tick && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear || done) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Ball position generator: serve, per-frame motion with wall/paddle bounces, miss hold-off.
module ball_motion_engine
    import pong_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    ball_motion_engine_if.slave bus
);

    ball_state_t state_q, state_d;
    coord_t      x_q, x_d, y_q, y_d;
    dir_t        dx_q, dx_d, dy_q, dy_d;
    logic        p1_q, p1_d, p2_q, p2_d;
    logic        ml_q, ml_d, mr_q, mr_d;
    logic        in_play_q, in_play_d;
    logic        timer_done;

    serve_timer #(
        .DELAY(SERVE_DELAY)
    ) u_serve_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q != MISS),
        .tick (bus.frame_tick),
        .done (timer_done)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        p1_d    = 1'b0;
        p2_d    = 1'b0;
        ml_d    = 1'b0;
        mr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.serve) state_d = PLAY;
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    if (dx_q == DIR_NEG) begin
                        if (x_q < PADDLE_WIDTH + SPEED_X) begin
                            if (paddle_hit(y_q, bus.Paddle1_Y)) begin
                                x_d  = PADDLE_WIDTH;
                                dx_d = DIR_POS;
                                p1_d = 1'b1;
                            end else begin
                                x_d     = '0;
                                ml_d    = 1'b1;
                                state_d = MISS;
                            end
                        end else begin
                            x_d = x_q - SPEED_X;
                        end
                    end else begin
                        if (x_q + BALL_SIZE + SPEED_X > PADDLE2_X) begin
                            if (paddle_hit(y_q, bus.Paddle2_Y)) begin
                                x_d  = PADDLE2_X - BALL_SIZE;
                                dx_d = DIR_NEG;
                                p2_d = 1'b1;
                            end else begin
                                x_d     = SCREEN_WIDTH - BALL_SIZE;
                                mr_d    = 1'b1;
                                state_d = MISS;
                            end
                        end else begin
                            x_d = x_q + SPEED_X;
                        end
                    end

                    if (dy_q == DIR_NEG) begin
                        if (y_q < SPEED_Y) begin
                            y_d  = '0;
                            dy_d = DIR_POS;
                        end else begin
                            y_d = y_q - SPEED_Y;
                        end
                    end else begin
                        if (y_q + BALL_SIZE + SPEED_Y > SCREEN_HEIGHT) begin
                            y_d  = SCREEN_HEIGHT - BALL_SIZE;
                            dy_d = DIR_NEG;
                        end else begin
                            y_d = y_q + SPEED_Y;
                        end
                    end
                end
            end
            MISS: begin
                // dx is left untouched: it still points toward the side that missed.
                if (timer_done) begin
                    x_d     = CENTER_X;
                    y_d     = CENTER_Y;
                    dy_d    = DIR_POS;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_play_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= CENTER_X;
            y_q       <= CENTER_Y;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            ml_q      <= 1'b0;
            mr_q      <= 1'b0;
            in_play_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            ml_q      <= ml_d;
            mr_q      <= mr_d;
            in_play_q <= in_play_d;
        end
    end

    assign bus.Ball_X            = x_q;
    assign bus.Ball_Y            = y_q;
    assign bus.paddle1_collision = p1_q;
    assign bus.paddle2_collision = p2_q;
    assign bus.miss_left         = ml_q;
    assign bus.miss_right        = mr_q;
    assign bus.in_play           = in_play_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: serve, walls, both paddles, miss hold-off, async reset.
module tb_ball_motion_engine;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ball_motion_engine_if bus();

    ball_motion_engine dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Each tick: frame_tick high for one cycle, returns on the negedge right after the
    // consuming posedge so outputs (including pulses) are sampled there.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_tick = 1'b1;
            @(negedge clk);
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic serve_pulse();
        @(negedge clk);
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
    endtask

    task automatic check_pos(input string tag, input logic [15:0] x, input logic [15:0] y);
        check({tag, "_x"}, bus.Ball_X, x);
        check({tag, "_y"}, bus.Ball_Y, y);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.serve      = 1'b0;
        bus.Paddle1_Y  = 16'd150;
        bus.Paddle2_Y  = 16'd0;
        repeat (2) @(negedge clk);

        check_pos("reset", 16'd316, 16'd236);
        check("reset_p1", bus.paddle1_collision, 16'd0);
        check("reset_p2", bus.paddle2_collision, 16'd0);
        check("reset_ml", bus.miss_left, 16'd0);
        check("reset_mr", bus.miss_right, 16'd0);
        check("reset_in_play", bus.in_play, 16'd0);
        rst_n = 1'b1;

        // frame_tick ignored in IDLE
        tick(2);
        check_pos("idle_hold", 16'd316, 16'd236);

        // Serve held high through PLAY and MISS must have no effect there.
        @(negedge clk);
        bus.serve = 1'b1;
        tick(1);
        check_pos("first_step", 16'd318, 16'd238);
        check("first_in_play", bus.in_play, 16'd1);
        tick(147);
        check_pos("pre_miss", 16'd612, 16'd414);
        tick(1);
        check_pos("miss_r", 16'd632, 16'd412);
        check("miss_r_pulse", bus.miss_right, 16'd1);
        check("miss_r_in_play", bus.in_play, 16'd0);
        @(negedge clk);
        check("miss_r_pulse_end", bus.miss_right, 16'd0);
        tick(59);
        check_pos("miss_hold59", 16'd632, 16'd412);
        check("miss_hold_in_play", bus.in_play, 16'd0);
        bus.serve = 1'b0;
        tick(1);
        check_pos("recentre", 16'd316, 16'd236);
        check("recentre_in_play", bus.in_play, 16'd0);
        tick(3);
        check_pos("idle_after_miss", 16'd316, 16'd236);

        // dx stays + after a right miss; then Paddle 2 hit.
        serve_pulse();
        tick(1);
        check_pos("reserve_step", 16'd318, 16'd238);
        tick(147);
        check_pos("pre_p2", 16'd612, 16'd414);
        bus.Paddle2_Y = 16'd380;
        tick(1);
        check_pos("p2_hit", 16'd612, 16'd412);
        check("p2_pulse", bus.paddle2_collision, 16'd1);
        @(negedge clk);
        check("p2_pulse_end", bus.paddle2_collision, 16'd0);

        // Top wall while moving up-left.
        tick(205);
        check_pos("near_top", 16'd202, 16'd2);
        tick(1);
        check_pos("top_clamp", 16'd200, 16'd0);
        tick(1);
        check_pos("top_bounce", 16'd198, 16'd0);
        tick(1);
        check_pos("top_leave", 16'd196, 16'd2);

        // Paddle 1 hit.
        tick(87);
        check_pos("pre_p1", 16'd22, 16'd176);
        tick(1);
        check_pos("p1_face", 16'd20, 16'd178);
        check("p1_face_pulse", bus.paddle1_collision, 16'd0);
        tick(1);
        check_pos("p1_hit", 16'd20, 16'd180);
        check("p1_pulse", bus.paddle1_collision, 16'd1);
        @(negedge clk);
        check("p1_pulse_end", bus.paddle1_collision, 16'd0);
        tick(1);
        check_pos("p1_rebound", 16'd22, 16'd182);

        // Asynchronous reset in the middle of MISS.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.Paddle2_Y = 16'd0;
        serve_pulse();
        tick(149);
        check("miss2_x", bus.Ball_X, 16'd632);
        tick(30);
        #2;
        rst_n = 1'b0;
        #1;
        check_pos("async_reset", 16'd316, 16'd236);
        check("async_reset_in_play", bus.in_play, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check_pos("after_reset_idle", 16'd316, 16'd236);
        serve_pulse();
        tick(1);
        check_pos("after_reset_step", 16'd318, 16'd238);
        tick(148);
        check_pos("miss3", 16'd632, 16'd412);
        check("miss3_pulse", bus.miss_right, 16'd1);
        tick(59);
        check_pos("timer_restart59", 16'd632, 16'd412);
        tick(1);
        check_pos("timer_restart60", 16'd316, 16'd236);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
